// File: rtl/an_decode_arbiter_if.sv
// Requester and result handshake bundle for the shared AN-code (A=29) decoder.
// master = requesters/sink side, slave = the arbiter/decoder.
interface an_decode_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*14-1:0] req_codeword;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [ID_W-1:0]       out_id;
    logic [9:0]            out_q;
    logic [4:0]            out_r;
    logic                  out_error;

    modport master (
        output req_valid, req_codeword, out_ready,
        input  req_ready, out_valid, out_id, out_q, out_r, out_error
    );

    modport slave (
        input  req_valid, req_codeword, out_ready,
        output req_ready, out_valid, out_id, out_q, out_r, out_error
    );
endinterface

// File: rtl/an_decode_arbiter.sv
// Round-robin arbiter sharing one registered A=29 Barrett decoder among NUM_REQ
// requesters; results carry the requester id and errors feed a saturating counter.
module an_decode_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    an_decode_arbiter_if.slave  bus,
    input  logic                err_clr,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Barrett estimate with 141/4096 ~ 1/29, then one correction step; returns {q, r, error}.
    function automatic logic [15:0] an_decode(input logic [13:0] cw);
        logic [9:0] q_est;
        logic [5:0] r_est;
        logic [9:0] q_fix;
        logic [4:0] r_fix;
        q_est = 10'(({8'd0, cw} * 22'd141) >> 12);
        r_est = 6'({1'b0, cw} - 15'({5'd0, q_est} * 15'd29));
        if (r_est >= 6'd29) begin
            q_fix = q_est + 10'd1;
            r_fix = 5'(r_est - 6'd29);
        end else begin
            q_fix = q_est;
            r_fix = r_est[4:0];
        end
        return {q_fix, r_fix, (r_fix != 5'd0)};
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [13:0]         cw_r;
    logic [ID_W-1:0]     id_r;
    logic                out_valid_r;
    logic [ID_W-1:0]     out_id_r;
    logic [9:0]          out_q_r;
    logic [4:0]          out_r_r;
    logic                out_error_r;
    logic [ERRCNT_W-1:0] err_cnt_r;
    logic                busy_r;

    logic                found_hi_s;
    logic                found_lo_s;
    logic [ID_W-1:0]     grant_hi_s;
    logic [ID_W-1:0]     grant_lo_s;
    logic                grant_found_s;
    logic [ID_W-1:0]     grant_s;
    logic [ID_W-1:0]     ptr_nxt_s;
    logic                accept_s;
    logic                hs_s;
    logic [13:0]         cw_sel_s;
    logic [NUM_REQ-1:0]  req_ready_s;

    // Round-robin pick: lowest valid index at/after rr_ptr, else lowest valid overall (wrap).
    always_comb begin
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        grant_hi_s = '0;
        grant_lo_s = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                found_lo_s = 1'b1;
                grant_lo_s = ID_W'(j);
                if (ID_W'(j) >= rr_ptr_r) begin
                    found_hi_s = 1'b1;
                    grant_hi_s = ID_W'(j);
                end else begin
                    found_hi_s = found_hi_s;
                end
            end else begin
                found_lo_s = found_lo_s;
            end
        end
        grant_found_s = found_hi_s | found_lo_s;
        grant_s       = found_hi_s ? grant_hi_s : grant_lo_s;
    end

    assign accept_s  = (state_r == ST_IDLE) && grant_found_s;
    assign hs_s      = (state_r == ST_HOLD) && bus.out_ready;
    assign ptr_nxt_s = (grant_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_s + ID_W'(1);

    // Codeword mux and one-hot ready; ready is held low while reset is asserted.
    always_comb begin
        cw_sel_s    = 14'd0;
        req_ready_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s == ID_W'(i)) begin
                cw_sel_s       = bus.req_codeword[i*14 +: 14];
                req_ready_s[i] = rst_n & accept_s;
            end else begin
                req_ready_s[i] = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Capture the granted word, decode it in CALC and hold the result until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= '0;
            cw_r        <= 14'd0;
            id_r        <= '0;
            out_valid_r <= 1'b0;
            out_id_r    <= '0;
            out_q_r     <= 10'd0;
            out_r_r     <= 5'd0;
            out_error_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                cw_r     <= cw_sel_s;
                id_r     <= grant_s;
                rr_ptr_r <= ptr_nxt_s;
            end
            if (state_r == ST_CALC) begin
                {out_q_r, out_r_r, out_error_r} <= an_decode(cw_r);
                out_id_r    <= id_r;
                out_valid_r <= 1'b1;
            end else if (hs_s) begin
                out_valid_r <= 1'b0;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // Saturating error counter; a clear beats a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
        end else if (err_clr) begin
            err_cnt_r <= '0;
        end else if (hs_s && out_error_r && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_id    = out_id_r;
    assign bus.out_q     = out_q_r;
    assign bus.out_r     = out_r_r;
    assign bus.out_error = out_error_r;
    assign err_cnt       = err_cnt_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_an_decode_arbiter.sv
// Self-checking bench for an_decode_arbiter: behavioural model compared every cycle,
// directed literal cases, and a randomized traffic phase.
module tb_an_decode_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int ERRCNT_W = 4;
    localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                err_clr = 1'b0;
    logic [ERRCNT_W-1:0] err_cnt;
    logic                busy;

    an_decode_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    an_decode_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_clr (err_clr),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: phase 0 = waiting, 1 = decoding, 2 = result offered.
    int   m_phase = 0;
    int   m_ptr   = 0;
    int   m_cnt   = 0;
    int   m_id    = 0;
    int   m_q     = 0;
    int   m_r     = 0;
    logic m_err   = 1'b0;

    always @(negedge clk) begin : model
        int g;
        int cw;
        logic [NUM_REQ-1:0]    exp_rdy;
        logic [NUM_REQ*14-1:0] sh;
        logic hs;
        if (!rst_n) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_id", bus.out_id, 0);
            chk("rst_out_q", bus.out_q, 0);
            chk("rst_out_r", bus.out_r, 0);
            chk("rst_out_error", bus.out_error, 0);
            chk("rst_err_cnt", err_cnt, 0);
            chk("rst_busy", busy, 0);
            m_phase = 0;
            m_ptr   = 0;
            m_cnt   = 0;
        end else begin
            g = -1;
            exp_rdy = '0;
            if (m_phase == 0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (g < 0 && bus.req_valid[(m_ptr + i) % NUM_REQ]) g = (m_ptr + i) % NUM_REQ;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("out_valid", bus.out_valid, (m_phase == 2));
            chk("busy", busy, (m_phase != 0));
            chk("err_cnt", err_cnt, m_cnt);
            if (m_phase == 2) begin
                chk("out_id", bus.out_id, m_id);
                chk("out_q", bus.out_q, m_q);
                chk("out_r", bus.out_r, m_r);
                chk("out_error", bus.out_error, m_err);
            end
            hs = (m_phase == 2) && bus.out_ready;
            if (err_clr) m_cnt = 0;
            else if (hs && m_err && m_cnt != CNT_MAX) m_cnt = m_cnt + 1;
            if (m_phase == 0 && g >= 0) begin
                sh      = bus.req_codeword >> (14 * g);
                cw      = int'(sh[13:0]);
                m_id    = g;
                m_q     = cw / 29;
                m_r     = cw % 29;
                m_err   = (m_r != 0);
                m_ptr   = (g + 1) % NUM_REQ;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (hs) begin
                m_phase = 0;
            end
        end
    end

    // One request from a single requester, with literal expectations and optional sink stall.
    task automatic directed(input int id, input logic [13:0] cw, input int eq, input int er,
                            input int ee, input int hold, input logic clr);
        logic got;
        got = 1'b0;
        bus.req_valid = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_codeword[id*14 +: 14] = cw;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", got, 1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("lat_n1_valid", bus.out_valid, 0);
        chk("lat_n1_busy", busy, 1);
        @(posedge clk); #1;
        err_clr = clr;
        bus.out_ready = (hold == 0);
        if (hold > 0) bus.req_valid = '1;
        @(negedge clk);
        chk("lat_n2_valid", bus.out_valid, 1);
        chk("lit_id", bus.out_id, id);
        chk("lit_q", bus.out_q, eq);
        chk("lit_r", bus.out_r, er);
        chk("lit_err", bus.out_error, ee);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (h == hold - 1) bus.out_ready = 1'b1;
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_q", bus.out_q, eq);
            chk("hold_r", bus.out_r, er);
            chk("hold_ready_low", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        err_clr = 1'b0;
        bus.req_valid = '0;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int got_id[5];
    int got_cyc[5];
    int n_gr;
    logic got_r;

    initial begin
        bus.req_valid    = '0;
        bus.req_codeword = '0;
        bus.out_ready    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_err_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        directed(0, 14'd2900, 100, 0, 0, 0, 1'b0);
        directed(1, 14'd2901, 100, 1, 1, 0, 1'b0);
        directed(1, 14'd2899, 99, 28, 1, 0, 1'b0);
        @(negedge clk);
        chk("err_cnt_two", err_cnt, 2);
        @(posedge clk); #1;
        directed(2, 14'd0, 0, 0, 0, 0, 1'b0);
        directed(3, 14'd16383, 564, 27, 1, 0, 1'b0);

        // All requesters busy: expect rotation 0,1,2,3,0 at one grant per three clocks.
        for (int i = 0; i < NUM_REQ; i++) bus.req_codeword[i*14 +: 14] = 14'(i * 100 + 7);
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        n_gr = 0;
        for (int c = 0; c < 60 && n_gr < 5; c++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) got_id[n_gr] = i;
                got_cyc[n_gr] = c;
                n_gr++;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("grant_count", n_gr, 5);
        for (int k = 0; k < n_gr; k++) chk("grant_order", got_id[k], exp_order[k]);
        for (int k = 1; k < n_gr; k++) chk("grant_spacing", got_cyc[k] - got_cyc[k-1], 3);

        directed(2, 14'd1000, 34, 14, 1, 5, 1'b0);

        // Reset while decoding, then confirm arbitration restarts at requester 0.
        bus.req_valid = 4'b0100;
        got_r = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.req_ready[2]) begin
                got_r = 1'b1;
                break;
            end
        end
        chk("rst_case_accept", got_r, 1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midcalc_valid", bus.out_valid, 0);
        chk("midcalc_busy", busy, 0);
        chk("midcalc_q", bus.out_q, 0);
        chk("midcalc_err_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_valid = '1;
        @(negedge clk);
        chk("post_rst_grant", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Saturation and clear-beats-increment.
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        for (int k = 0; k < CNT_MAX + 1; k++) directed(0, 14'd30, 1, 1, 1, 0, 1'b0);
        @(negedge clk);
        chk("err_cnt_sat", err_cnt, CNT_MAX);
        @(posedge clk); #1;
        directed(0, 14'd30, 1, 1, 1, 0, 1'b0);
        @(negedge clk);
        chk("err_cnt_stay_sat", err_cnt, CNT_MAX);
        @(posedge clk); #1;
        directed(1, 14'd59, 2, 1, 1, 0, 1'b1);
        @(negedge clk);
        chk("err_clr_wins", err_cnt, 0);
        @(posedge clk); #1;

        // Randomized traffic checked by the model.
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++)
                bus.req_codeword[i*14 +: 14] = 14'($urandom_range(0, 16383));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        err_clr = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
